// File: rtl/priority_encoder_drain.sv
// ---------------------------------------------------------------------------
// priority_encoder_drain
//
// Latches a WIDTH-bit request vector through a valid/ready handshake and
// emits the index of every set bit, one per output handshake, in priority
// order. Each bit is cleared as it is served.
//
// Optional feature (macro PRIORITY_ENCODER_DRAIN_RR_EN):
//   defined   - round-robin selection. The search starts at ptr and wraps.
//               ptr advances past each served index and persists across
//               vectors.
//   undefined - lowest-index-first selection. No ptr register is built.
//
// Ports:
//   clk_i        in   clock, rising edge
//   reset_i      in   synchronous active-high reset
//   vec_valid_i  in   hot_vector_i valid
//   vec_ready_o  out  block can accept a new vector (IDLE)
//   hot_vector_i in   request vector, bit i set = request i pending
//   idx_valid_o  out  idx_o valid (DRAIN)
//   idx_ready_i  in   downstream accepts idx_o
//   idx_o        out  index of currently selected set bit
//   last_o       out  idx_o is the final index of the current vector
//   empty_o      out  one-cycle pulse after an all-zero vector was accepted
// ---------------------------------------------------------------------------
module priority_encoder_drain #(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             vec_valid_i,
    output logic             vec_ready_o,
    input  logic [WIDTH-1:0] hot_vector_i,
    output logic             idx_valid_o,
    input  logic             idx_ready_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             last_o,
    output logic             empty_o
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             empty_q, empty_d;

    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] sel_mask;
    logic [IDX_W-1:0] sel_idx;
    logic             found;
    logic             one_left;

`ifdef PRIORITY_ENCODER_DRAIN_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] upper;

    // Bits at or above ptr are preferred. If none of them is pending, the
    // search wraps, which reduces to a plain lowest-first scan of pending.
    always_comb begin
        upper = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            upper[i] = (IDX_W'(i) >= ptr_q);
        end
        cand = pending_q & upper;
        if (cand == '0) begin
            cand = pending_q;
        end
    end
`else
    always_comb begin
        cand = pending_q;
    end
`endif

    // Lowest-set-bit scan of the candidate set.
    always_comb begin
        found    = 1'b0;
        sel_idx  = '0;
        sel_mask = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (!found && cand[i]) begin
                found       = 1'b1;
                sel_idx     = IDX_W'(i);
                sel_mask[i] = 1'b1;
            end
        end
    end

    // pending is never zero in DRAIN, so "no second bit" means exactly one.
    assign one_left = ((pending_q & (pending_q - WIDTH'(1))) == '0);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        empty_d   = 1'b0;
`ifdef PRIORITY_ENCODER_DRAIN_RR_EN
        ptr_d     = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (vec_valid_i) begin
                    if (hot_vector_i != '0) begin
                        pending_d = hot_vector_i;
                        state_d   = DRAIN;
                    end else begin
                        empty_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (idx_ready_i) begin
                    pending_d = pending_q & ~sel_mask;
`ifdef PRIORITY_ENCODER_DRAIN_RR_EN
                    ptr_d = (sel_idx == IDX_W'(WIDTH - 1)) ? '0 : sel_idx + IDX_W'(1);
`endif
                    if (one_left) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            pending_q <= '0;
            empty_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            empty_q   <= empty_d;
        end
    end

`ifdef PRIORITY_ENCODER_DRAIN_RR_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign vec_ready_o = (state_q == IDLE);
    assign idx_valid_o = (state_q == DRAIN);
    assign idx_o       = (state_q == DRAIN) ? sel_idx : '0;
    assign last_o      = (state_q == DRAIN) && one_left;
    assign empty_o     = empty_q;

endmodule

// File: doc/priority_encoder_drain.md
Name: priority_encoder_drain

Overview:
- Parametrised, sequential successor to the team's 4-bit combinational priority encoder.
- Accepts a WIDTH-bit hot vector through a valid/ready handshake and latches it.
- Emits the index of every set bit, one per output handshake, in priority order, clearing each bit as it is served.
- Used wherever a multi-request vector (interrupt/event flags, spike masks) must be serialised into a stream of indices.

Parameters:
- WIDTH, 16, hot-vector width; legal range 2..256, power of two not required.
- IDX_W, $clog2(WIDTH), index width; derived, not to be overridden.

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- reset_i  input  1  synchronous, active-high reset
- vec_valid_i  input  1  hot_vector_i valid
- vec_ready_o  output  1  block can accept a new vector
- hot_vector_i  input  WIDTH  request vector; bit i set = request i pending
- idx_valid_o  output  1  idx_o valid
- idx_ready_i  input  1  downstream accepts idx_o
- idx_o  output  IDX_W  index of currently selected set bit
- last_o  output  1  idx_o is the final index of the current vector
- empty_o  output  1  one-cycle pulse: an all-zero vector was accepted

Behaviour:
- Reset is synchronous and active-high. One clock, clk_i; no other clock domains.
- Reset values: state=IDLE, pending=0, ptr=0, vec_ready_o=1, idx_valid_o=0, idx_o=0, last_o=0, empty_o=0.
- State machine: two states, IDLE and DRAIN. Internal registers: pending[WIDTH-1:0] and ptr[IDX_W-1:0]; ptr is used only with the optional feature.
- IDLE:
  - vec_ready_o=1, idx_valid_o=0.
  - Acceptance occurs when vec_valid_i && vec_ready_o.
  - Nonzero vector accepted: pending <= hot_vector_i; next state DRAIN.
  - Zero vector accepted: stay in IDLE; empty_o=1 on the following cycle only.
- DRAIN:
  - vec_ready_o=0; vec_valid_i and hot_vector_i are ignored.
  - idx_valid_o=1, idx_o = selected set bit of pending.
  - last_o=1 iff pending has exactly one bit set.
- Selection (default): lowest-numbered set bit of pending.
- Output handshake occurs when idx_valid_o && idx_ready_i:
  - The selected bit of pending is cleared.
  - If last_o=1, next state is IDLE and vec_ready_o=1 on the next cycle.
  - Otherwise idx_o moves to the next selected bit on the next cycle.
- Latency and throughput:
  - First index is valid one cycle after vector acceptance.
  - With idx_ready_i held high, one index per cycle.
  - A vector with K set bits occupies K+1 cycles from acceptance to vec_ready_o re-asserting.
  - No overlap between vectors: a new vector is never accepted in the same cycle as the last output handshake.
- Backpressure: while idx_valid_o=1 && idx_ready_i=0, idx_o, last_o and pending are held stable.
- idx_o, last_o and idx_valid_o are decoded from registered state only; there is no combinational path from any input.
- Priority logic is a generic loop/scan over WIDTH, not a hardcoded casex.
- Reset asserted mid-DRAIN: remaining pending bits are discarded and all outputs return to reset values on the next edge.
- reset_i overrides every simultaneous handshake.

Optional Feature:
- Macro: PRIORITY_ENCODER_DRAIN_RR_EN.
- Defined (round-robin selection):
  - Selection is the first set bit of pending at or above ptr, searching upward and wrapping from WIDTH-1 to 0.
  - On every output handshake, ptr <= (idx_o + 1) mod WIDTH.
  - ptr persists across vectors and is reset only by reset_i.
  - last_o, empty_o and handshake rules are unchanged.
- Undefined: ptr logic is not synthesised and selection is always lowest-index-first.

Test Plan:
1. Reset, WIDTH=8: hold reset_i 2 cycles, then release -> vec_ready_o=1, idx_valid_o=0, idx_o=0, last_o=0, empty_o=0.
2. Basic drain: accept 8'b1010_0100 with idx_ready_i=1 -> idx_o=2, 5, 7 on 3 consecutive cycles starting 1 cycle after acceptance; last_o=1 only with 7; vec_ready_o=1 the cycle after.
3. Backpressure: accept 8'b0000_1001, hold idx_ready_i=0 for 3 cycles -> idx_o=0 and last_o=0 held; raise idx_ready_i -> idx_o=0 then idx_o=3 with last_o=1.
4. Zero vector: accept 8'h00 -> empty_o=1 for exactly one cycle, idx_valid_o stays 0, vec_ready_o stays 1.
5. Reset mid-drain: accept 8'hFF, complete 2 handshakes, assert reset_i -> next cycle IDLE with idx_valid_o=0; then accept 8'h80 -> single idx_o=7 with last_o=1.
6. Round-robin (RR_EN defined, WIDTH=8): accept 8'b0001_0010 -> idx_o=1, 4 (ptr=5); then accept 8'b0100_0001 -> idx_o=6, then idx_o=0 with last_o=1; without the macro, the second vector yields idx_o=0, then 6.
